id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 in_valid  in  1  decode stage presents a decoded instruction.
REQ-004 in_ready  out  1  stage accepts the presented instruction this cycle.
REQ-005 ctrl_in  in  21  decoded control bundle: IsJAL, RegWrite, MemtoReg, IsCOP0, MemWrite, MemRead, IsJR, Branch, BneOrBeq, Jump, ALUop[3:0], ALUSrc, IsShamt, IsSyscall, ZeroExtend, RegDst, ReadRs, ReadRt.
REQ-006 rs_in, rt_in, rd_in  in  5 each  register specifiers; pc_in, rs_data_in, rt_data_in, imm_in  in  32 each.
REQ-007 flush  in  1  redirect from branch/jump resolution; kills held and incoming instruction.
REQ-008 resume  in  1  single-cycle pulse ending syscall halt.
REQ-009 out_valid  out  1; out_ready  in  1  execute-side handshake.
REQ-010 ctrl_out, rs_out, rt_out, rd_out, pc_out, rs_data_out, rt_data_out, imm_out  out  widths as inputs; registered copies.
REQ-011 dest_out  out  5  destination register: 31 if IsJAL, else rd if RegDst, else rt.
REQ-012 halted  out  1  stage is in HALT state; stall_count  out  16  saturating count of hazard-stall cycles.

Function
REQ-013 Storage SHALL be a single-entry register with states EMPTY, FULL, HALT.
REQ-014 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready; out_valid SHALL equal (state == FULL).
REQ-015 in_ready SHALL be 1 in EMPTY, equal out_ready in FULL, 0 in HALT, and forced 0 by a load-use hazard (REQ-018) except during flush.
REQ-016 Simultaneous transfer out and in while FULL SHALL replace the entry with zero-bubble latency; state remains FULL.
REQ-017 Latency SHALL be exactly one cycle from accepted input to out_valid.
REQ-018 Load-use hazard SHALL be: state FULL, held MemRead && RegWrite, dest_out != 0, in_valid, and ((ctrl_in.ReadRs && rs_in == dest_out) || (ctrl_in.ReadRt && rt_in == dest_out)).
REQ-019 On hazard, the held load SHALL drain normally; stage becomes EMPTY, producing exactly one bubble before the dependent instruction is accepted.
REQ-020 stall_count SHALL increment once per hazard cycle and saturate at 16'hFFFF.
REQ-021 flush SHALL have priority over every other event: next state EMPTY, in_ready 1 (incoming instruction consumed and discarded), out_valid 0 next cycle; flush in HALT SHALL be ignored.
REQ-022 Transfer out of an entry with IsSyscall SHALL move the stage to HALT; resume in HALT SHALL return to EMPTY next cycle; resume outside HALT SHALL be ignored.
REQ-023 Data outputs SHALL hold their last value when not loaded; consumers SHALL qualify with out_valid.

Reset
REQ-024 rst SHALL force state EMPTY, out_valid 0, halted 0, stall_count 0, ctrl_out 0, all data outputs 0, immediately and independent of clk.
REQ-025 rst asserted mid-transfer SHALL discard the held entry; no partial update after deassertion.

Configuration
REQ-026 Macro ID_EX_HAZARD_STALL_EN defined: REQ-018..REQ-020 active.
REQ-027 Macro ID_EX_HAZARD_STALL_EN undefined: no hazard detection, in_ready never forced 0 by hazard, stall_count constant 0 (software scheduling of load delay).

Structure
REQ-028 A shared package/header SHALL define the 21-bit control-bundle field positions, ALUop encodings, state encodings, and the constant JAL link register (31).
REQ-029 One sub-module, id_ex_hazard, SHALL contain the REQ-018 comparator, combinational only.

Verification
REQ-030 Back-to-back ADDs, out_ready=1: every cycle one accept and one emit, out_valid continuous, stall_count 0.
REQ-031 LW $8 held, incoming ADD reading rs=8: in_ready=0 one cycle, one bubble, ADD emitted cycle after LW, stall_count=1.
REQ-032 LW $0 held, incoming reading rs=0: no stall; JAL held with MemRead=0: dest_out=31, no stall.
REQ-033 FULL, out_ready=0, flush=1 with in_valid=1: next cycle out_valid=0, state EMPTY, incoming not emitted.
REQ-034 SYSCALL emitted: halted=1, in_ready=0 for 10 cycles with flush pulses; resume pulse: halted=0, next instruction accepted the following cycle.
REQ-035 rst asserted asynchronously while FULL: out_valid and ctrl_out 0 before next clk edge; 70000 hazard cycles: stall_count=16'hFFFF.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-bundle layout,
// ALU operation codes, storage states and the JAL link register.
package id_ex_stage_pkg;

    localparam int         CTRL_W  = 21;
    localparam logic [4:0] JAL_REG = 5'd31;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    // Field order fixes the bit positions: is_jal is bit 20, read_rt is bit 0.
    typedef struct packed {
        logic    is_jal;
        logic    reg_write;
        logic    mem_to_reg;
        logic    is_cop0;
        logic    mem_write;
        logic    mem_read;
        logic    is_jr;
        logic    branch;
        logic    bne_or_beq;
        logic    jump;
        alu_op_e alu_op;
        logic    alu_src;
        logic    is_shamt;
        logic    is_syscall;
        logic    zero_extend;
        logic    reg_dst;
        logic    read_rs;
        logic    read_rt;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    function automatic logic [4:0] dest_sel(input logic is_jal, input logic reg_dst,
                                            input logic [4:0] rd, input logic [4:0] rt);
        if (is_jal)
            return JAL_REG;
        else if (reg_dst)
            return rd;
        else
            return rt;
    endfunction

endpackage

// File: rtl/id_ex_hazard.sv
// Load-use hazard comparator: a held load whose destination is read by the
// instruction currently offered by decode. Purely combinational.
module id_ex_hazard (
    input  logic       en_i,
    input  logic       full_i,
    input  logic       held_mem_read_i,
    input  logic       held_reg_write_i,
    input  logic [4:0] dest_i,
    input  logic       in_valid_i,
    input  logic       read_rs_i,
    input  logic       read_rt_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    output logic       hazard_o
);

    logic src_match;

    assign src_match = (read_rs_i && (rs_i == dest_i)) || (read_rt_i && (rt_i == dest_i));

    assign hazard_o = en_i && full_i && held_mem_read_i && held_reg_write_i &&
                      (dest_i != 5'd0) && in_valid_i && src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX single-entry pipeline register with load-use stall, flush and syscall halt.
// Define ID_EX_HAZARD_STALL_EN to enable load-use hazard stalling and stall counting.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [4:0]        rs_in,
    input  logic [4:0]        rt_in,
    input  logic [4:0]        rd_in,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       rs_data_in,
    input  logic [31:0]       rt_data_in,
    input  logic [31:0]       imm_in,
    input  logic              flush,
    input  logic              resume,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [4:0]        rs_out,
    output logic [4:0]        rt_out,
    output logic [4:0]        rd_out,
    output logic [31:0]       pc_out,
    output logic [31:0]       rs_data_out,
    output logic [31:0]       rt_data_out,
    output logic [31:0]       imm_out,
    output logic [4:0]        dest_out,
    output logic              halted,
    output logic [15:0]       stall_count
);

`ifdef ID_EX_HAZARD_STALL_EN
    localparam bit HAZARD_EN = 1'b1;
`else
    localparam bit HAZARD_EN = 1'b0;
`endif

    state_e      state_q, state_d;
    ctrl_t       ctrl_q;
    ctrl_t       ctrl_new;
    logic [4:0]  rs_q, rt_q, rd_q;
    logic [31:0] pc_q, rs_data_q, rt_data_q, imm_q;
    logic [15:0] stall_q, stall_d;
    logic        hazard;
    logic        out_fire;
    logic        load_en;

    assign ctrl_new = ctrl_t'(ctrl_in);
    assign dest_out = dest_sel(ctrl_q.is_jal, ctrl_q.reg_dst, rd_q, rt_q);

    id_ex_hazard u_hazard (
        .en_i             (HAZARD_EN),
        .full_i           (state_q == ST_FULL),
        .held_mem_read_i  (ctrl_q.mem_read),
        .held_reg_write_i (ctrl_q.reg_write),
        .dest_i           (dest_out),
        .in_valid_i       (in_valid),
        .read_rs_i        (ctrl_new.read_rs),
        .read_rt_i        (ctrl_new.read_rt),
        .rs_i             (rs_in),
        .rt_i             (rt_in),
        .hazard_o         (hazard)
    );

    assign out_valid = (state_q == ST_FULL);
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        load_en  = 1'b0;
        stall_d  = stall_q;
        if (hazard && !flush && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
        unique case (state_q)
            ST_EMPTY: begin
                in_ready = 1'b1;
                if (flush) begin
                    state_d = ST_EMPTY;
                end else if (in_valid) begin
                    load_en = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                in_ready = flush ? 1'b1 : (out_ready && !hazard);
                if (flush) begin
                    state_d = ST_EMPTY;
                end else if (out_fire && ctrl_q.is_syscall) begin
                    // The syscall redirects fetch, so anything accepted alongside it is dropped.
                    state_d = ST_HALT;
                end else if (out_fire) begin
                    load_en = in_valid && in_ready;
                    state_d = load_en ? ST_FULL : ST_EMPTY;
                end
            end
            ST_HALT: begin
                if (resume)
                    state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            stall_q   <= 16'd0;
            ctrl_q    <= '0;
            rs_q      <= 5'd0;
            rt_q      <= 5'd0;
            rd_q      <= 5'd0;
            pc_q      <= 32'd0;
            rs_data_q <= 32'd0;
            rt_data_q <= 32'd0;
            imm_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            if (load_en) begin
                ctrl_q    <= ctrl_new;
                rs_q      <= rs_in;
                rt_q      <= rt_in;
                rd_q      <= rd_in;
                pc_q      <= pc_in;
                rs_data_q <= rs_data_in;
                rt_data_q <= rt_data_in;
                imm_q     <= imm_in;
            end
        end
    end

    assign ctrl_out    = ctrl_q;
    assign rs_out      = rs_q;
    assign rt_out      = rt_q;
    assign rd_out      = rd_q;
    assign pc_out      = pc_q;
    assign rs_data_out = rs_data_q;
    assign rt_data_out = rt_data_q;
    assign imm_out     = imm_q;
    assign halted      = (state_q == ST_HALT);
    assign stall_count = stall_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow ID_EX_HAZARD_STALL_EN.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

`ifdef ID_EX_HAZARD_STALL_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [20:0] ctrl_in, ctrl_out;
    logic [4:0]  rs_in, rt_in, rd_in, rs_out, rt_out, rd_out, dest_out;
    logic [31:0] pc_in, rs_data_in, rt_data_in, imm_in;
    logic [31:0] pc_out, rs_data_out, rt_data_out, imm_out;
    logic        flush, resume, out_valid, out_ready, halted;
    logic [15:0] stall_count;

    int total = 0;
    int bad   = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ctrl_in(ctrl_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .pc_in(pc_in), .rs_data_in(rs_data_in), .rt_data_in(rt_data_in), .imm_in(imm_in),
        .flush(flush), .resume(resume), .out_valid(out_valid), .out_ready(out_ready),
        .ctrl_out(ctrl_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .pc_out(pc_out), .rs_data_out(rs_data_out), .rt_data_out(rt_data_out),
        .imm_out(imm_out), .dest_out(dest_out), .halted(halted), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctrl_t mk_add();
        ctrl_t c = '0;
        c.reg_write = 1'b1; c.reg_dst = 1'b1; c.read_rs = 1'b1; c.read_rt = 1'b1;
        c.alu_op = ALU_ADD;
        return c;
    endfunction

    function automatic ctrl_t mk_lw();
        ctrl_t c = '0;
        c.reg_write = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1;
        c.alu_src = 1'b1; c.read_rs = 1'b1; c.alu_op = ALU_ADD;
        return c;
    endfunction

    function automatic ctrl_t mk_jal();
        ctrl_t c = '0;
        c.is_jal = 1'b1; c.reg_write = 1'b1; c.jump = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t mk_sys();
        ctrl_t c = '0;
        c.is_syscall = 1'b1;
        return c;
    endfunction

    task automatic set_in(input ctrl_t c, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] pc);
        ctrl_in    = c;
        rs_in      = rs;
        rt_in      = rt;
        rd_in      = rd;
        pc_in      = pc;
        rs_data_in = pc ^ 32'hA5A5_0000;
        rt_data_in = ~pc;
        imm_in     = pc + 32'd1;
        in_valid   = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; resume = 1'b0; out_ready = 1'b0;
        ctrl_in = '0; rs_in = '0; rt_in = '0; rd_in = '0;
        pc_in = '0; rs_data_in = '0; rt_data_in = '0; imm_in = '0;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_count); end
        total++; if (ctrl_out !== 21'd0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", ctrl_out); end
        total++; if (pc_out !== 32'd0 || rs_data_out !== 32'd0 || imm_out !== 32'd0)
            begin bad++; $display("FAIL reset_data pc=%h rs_data=%h imm=%h exp=0", pc_out, rs_data_out, imm_out); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
        $display("reset: released");
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pc = 32'h100 + 32'(4 * i);
            set_in(mk_add(), 5'd1, 5'd2, 5'(i + 10), pc);
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, in_ready); end
            tick();
            total++; if (out_valid !== 1'b1 || pc_out !== pc || rt_data_out !== ~pc)
                begin bad++; $display("FAIL b2b_emit[%0d] valid=%b pc=%h rt_data=%h exp pc=%h", i, out_valid, pc_out, rt_data_out, pc); end
            total++; if (dest_out !== 5'(i + 10)) begin bad++; $display("FAIL b2b_dest[%0d] got=%0d exp=%0d", i, dest_out, i + 10); end
            $display("b2b: add pc=%h emitted", pc);
        end
        in_valid = 1'b0;
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL b2b_stall got=%0d exp=0", stall_count); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_load_use();
        set_in(mk_lw(), 5'd2, 5'd8, 5'd0, 32'h400);
        tick();
        total++; if (out_valid !== 1'b1 || dest_out !== 5'd8)
            begin bad++; $display("FAIL lu_hold valid=%b dest=%0d exp valid=1 dest=8", out_valid, dest_out); end
        set_in(mk_add(), 5'd8, 5'd3, 5'd9, 32'h404);
        #1;
        total++; if (in_ready !== !HZ) begin bad++; $display("FAIL lu_in_ready got=%b exp=%b", in_ready, !HZ); end
        tick();
        total++; if (out_valid !== !HZ) begin bad++; $display("FAIL lu_bubble got=%b exp=%b", out_valid, !HZ); end
        total++; if (stall_count !== (HZ ? 16'd1 : 16'd0))
            begin bad++; $display("FAIL lu_stall got=%0d exp=%0d", stall_count, HZ ? 1 : 0); end
        if (HZ) tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || pc_out !== 32'h404 || rd_out !== 5'd9)
            begin bad++; $display("FAIL lu_add_emit valid=%b pc=%h rd=%0d exp pc=404 rd=9", out_valid, pc_out, rd_out); end
        $display("load_use: add emitted pc=%h stall=%0d", pc_out, stall_count);
        tick();
    endtask

    task automatic test_no_stall();
        set_in(mk_lw(), 5'd8, 5'd0, 5'd0, 32'h500);
        tick();
        set_in(mk_add(), 5'd0, 5'd0, 5'd4, 32'h504);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL r0_in_ready got=%b exp=1", in_ready); end
        tick();
        total++; if (out_valid !== 1'b1 || pc_out !== 32'h504)
            begin bad++; $display("FAIL r0_emit valid=%b pc=%h exp pc=504", out_valid, pc_out); end
        set_in(mk_jal(), 5'd0, 5'd6, 5'd5, 32'h508);
        tick();
        total++; if (dest_out !== 5'd31) begin bad++; $display("FAIL jal_dest got=%0d exp=31", dest_out); end
        set_in(mk_add(), 5'd31, 5'd31, 5'd7, 32'h50C);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL jal_in_ready got=%b exp=1", in_ready); end
        tick();
        total++; if (pc_out !== 32'h50C) begin bad++; $display("FAIL jal_next_pc got=%h exp=50c", pc_out); end
        total++; if (stall_count !== (HZ ? 16'd1 : 16'd0))
            begin bad++; $display("FAIL no_stall_count got=%0d exp=%0d", stall_count, HZ ? 1 : 0); end
        in_valid = 1'b0;
        $display("no_stall: r0 and jal cases done");
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        set_in(mk_add(), 5'd1, 5'd2, 5'd3, 32'h200);
        tick();
        out_ready = 1'b0;
        set_in(mk_add(), 5'd1, 5'd2, 5'd4, 32'h204);
        flush = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || pc_out !== 32'h200)
            begin bad++; $display("FAIL flush_discard valid=%b pc=%h exp valid=0 pc=200", out_valid, pc_out); end
        $display("flush: entry and incoming discarded");
    endtask

    task automatic test_syscall();
        out_ready = 1'b1;
        set_in(mk_sys(), 5'd0, 5'd0, 5'd0, 32'h300);
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (halted !== 1'b1 || out_valid !== 1'b0)
            begin bad++; $display("FAIL sys_halt halted=%b valid=%b exp 1/0", halted, out_valid); end
        for (int i = 0; i < 10; i++) begin
            set_in(mk_add(), 5'd1, 5'd2, 5'd3, 32'h304);
            flush = i[0];
            #1;
            total++; if (in_ready !== 1'b0 || halted !== 1'b1)
                begin bad++; $display("FAIL sys_hold[%0d] in_ready=%b halted=%b exp 0/1", i, in_ready, halted); end
            tick();
        end
        flush = 1'b0;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        total++; if (halted !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL sys_resume halted=%b in_ready=%b exp 0/1", halted, in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || pc_out !== 32'h304)
            begin bad++; $display("FAIL sys_after valid=%b pc=%h exp pc=304", out_valid, pc_out); end
        $display("syscall: halted 10 cycles then resumed");
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        set_in(mk_add(), 5'd1, 5'd2, 5'd3, 32'h600);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL areset_pre got=%b exp=1", out_valid); end
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || ctrl_out !== 21'd0 || pc_out !== 32'd0)
            begin bad++; $display("FAIL areset_now valid=%b ctrl=%h pc=%h exp 0", out_valid, ctrl_out, pc_out); end
        #3 rst = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_after got=%b exp=0", out_valid); end
        $display("async_reset: entry discarded");
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        set_in(mk_lw(), 5'd2, 5'd8, 5'd0, 32'h700);
        tick();
        out_ready = 1'b0;
        set_in(mk_add(), 5'd8, 5'd8, 5'd9, 32'h704);
        repeat (100) tick();
        total++; if (stall_count !== (HZ ? 16'd100 : 16'd0))
            begin bad++; $display("FAIL sat_100 got=%0d exp=%0d", stall_count, HZ ? 100 : 0); end
        repeat (69900) tick();
        total++; if (stall_count !== (HZ ? 16'hFFFF : 16'd0))
            begin bad++; $display("FAIL sat_max got=%h exp=%h", stall_count, HZ ? 16'hFFFF : 16'h0); end
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
            begin bad++; $display("FAIL sat_hold in_ready=%b valid=%b exp 0/1", in_ready, out_valid); end
        $display("saturate: stall_count=%h", stall_count);
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_no_stall();
        test_flush();
        test_syscall();
        test_async_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
